// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module  : bus_arb_pkg
// Desc    : Shared types and helpers for the round-robin bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

   localparam int BE_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Wrapping increment for non-power-of-2 master counts.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Desc    : Combinational round-robin picker: first request at or after ptr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] grant_idx,
   output logic            any_req
);

   logic [2*N-1:0] w_mask;
   logic [2*N-1:0] w_dbl;

   // Upper copy of req supplies the wrapped-around candidates below ptr.
   always_comb begin : p_pick
      int idx;
      w_mask = '0;
      for (int i = 0; i < 2*N; i++) begin
         w_mask[i] = (i >= int'(ptr));
      end
      w_dbl = {req, req} & w_mask;
      idx   = 0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (w_dbl[i]) idx = i;
      end
      if (idx >= N) idx = idx - N;
      grant_idx = ID_W'(idx);
      any_req   = |req;
   end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module  : bus_arbiter_rr
// Desc    : N-master to 1-slave round-robin arbiter with lock and watchdog.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int ID_W      = $clog2(N_MASTERS),
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 256
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [N_MASTERS-1:0]        i_bus_en,
   input  logic [N_MASTERS-1:0]        i_wr_rd,
   input  logic [N_MASTERS*DATA_W-1:0] i_wr_data,
   input  logic [N_MASTERS*DATA_W-1:0] i_addr,
   input  logic [N_MASTERS*BE_W-1:0]   i_byte_en,
   input  logic [N_MASTERS-1:0]        i_atomic,
   output logic [N_MASTERS-1:0]        o_ack,
   output logic [N_MASTERS-1:0]        o_err,
   output logic [N_MASTERS*DATA_W-1:0] o_rd_data,
   input  logic                        i_ack,
   input  logic [DATA_W-1:0]           i_rd_data,
   output logic                        o_bus_en,
   output logic                        o_wr_en,
   output logic [DATA_W-1:0]           o_wr_data,
   output logic [DATA_W-1:0]           o_addr,
   output logic [BE_W-1:0]             o_byte_en,
   output logic                        o_atomic,
   output logic [ID_W-1:0]             o_id
);

   localparam int c_wd_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

   state_t              r_state, w_state_nxt;
   logic [ID_W-1:0]     r_owner, w_owner_nxt;
   logic [ID_W-1:0]     r_rr_ptr, w_ptr_nxt;
   logic [c_wd_w-1:0]   r_wd_cnt, w_wd_nxt;

   logic [DATA_W-1:0]   w_addr    [N_MASTERS];
   logic [DATA_W-1:0]   w_wr_data [N_MASTERS];
   logic [BE_W-1:0]     w_byte_en [N_MASTERS];

   logic [ID_W-1:0]     w_grant_idx;
   logic                w_any_req;
   logic                w_busy;
   logic                w_own_req;
   logic                w_own_atomic;
   logic                w_wd_fire;
   logic [ID_W-1:0]     w_ptr_adv;

   for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
      assign w_addr[k]    = i_addr[k*DATA_W +: DATA_W];
      assign w_wr_data[k] = i_wr_data[k*DATA_W +: DATA_W];
      assign w_byte_en[k] = i_byte_en[k*BE_W +: BE_W];
   end

   rr_pick #(
      .N    (N_MASTERS),
      .ID_W (ID_W)
   ) u_pick (
      .req       (i_bus_en),
      .ptr       (r_rr_ptr),
      .grant_idx (w_grant_idx),
      .any_req   (w_any_req)
   );

   assign w_busy       = (r_state == BUSY);
   assign w_own_req    = i_bus_en[r_owner];
   assign w_own_atomic = i_atomic[r_owner];
   assign w_ptr_adv    = ID_W'(rr_next(int'(r_owner), N_MASTERS));
   // Abort takes precedence, so the watchdog only fires on a still-held request.
   assign w_wd_fire    = (TIMEOUT != 0) && w_busy && w_own_req && !i_ack
                         && (r_wd_cnt == c_wd_last);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_wd_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_ptr_nxt;
         r_wd_cnt <= w_wd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_rr_ptr;
      w_wd_nxt    = r_wd_cnt;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_owner_nxt = w_grant_idx;
               w_state_nxt = BUSY;
               w_wd_nxt    = '0;
            end
         end
         BUSY: begin
            if (!w_own_req) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = w_ptr_adv;
            end else if (i_ack && w_own_atomic) begin
               w_wd_nxt    = '0;
            end else if (i_ack) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = w_ptr_adv;
               w_wd_nxt    = '0;
            end else if (w_wd_fire) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = w_ptr_adv;
            end else if (r_wd_cnt != '1) begin
               w_wd_nxt    = r_wd_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_ack     = '0;
      o_err     = '0;
      o_rd_data = '0;
      o_bus_en  = 1'b0;
      o_wr_en   = 1'b0;
      o_wr_data = '0;
      o_addr    = '0;
      o_byte_en = '0;
      o_atomic  = 1'b0;
      o_id      = '0;
      if (w_busy) begin
         o_bus_en  = w_own_req && !w_wd_fire;
         o_wr_en   = i_wr_rd[r_owner];
         o_wr_data = w_wr_data[r_owner];
         o_addr    = w_addr[r_owner];
         o_byte_en = w_byte_en[r_owner];
         o_atomic  = w_own_atomic;
         o_id      = r_owner;
         o_ack[r_owner] = i_ack || w_wd_fire;
         o_err[r_owner] = w_wd_fire;
         o_rd_data[int'(r_owner)*DATA_W +: DATA_W] = i_rd_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
// ============================================================================
// Module  : tb_bus_arbiter_rr
// Desc    : Directed scoreboard bench for bus_arbiter_rr (N=4, TIMEOUT=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_rr;

   localparam int N  = 4;
   localparam int DW = 32;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [N-1:0]      i_bus_en;
   logic [N-1:0]      i_wr_rd;
   logic [N*DW-1:0]   i_wr_data;
   logic [N*DW-1:0]   i_addr;
   logic [N*4-1:0]    i_byte_en;
   logic [N-1:0]      i_atomic;
   logic [N-1:0]      o_ack;
   logic [N-1:0]      o_err;
   logic [N*DW-1:0]   o_rd_data;
   logic              i_ack;
   logic [DW-1:0]     i_rd_data;
   logic              o_bus_en;
   logic              o_wr_en;
   logic [DW-1:0]     o_wr_data;
   logic [DW-1:0]     o_addr;
   logic [3:0]        o_byte_en;
   logic              o_atomic;
   logic [1:0]        o_id;

   logic [DW-1:0]     m_addr  [N];
   logic [DW-1:0]     m_wdata [N];
   logic [3:0]        m_be    [N];

   typedef struct {
      logic [1:0]      id;
      logic [N-1:0]    ack;
      logic [N-1:0]    err;
      logic [N*DW-1:0] rd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   assign i_addr    = {m_addr[3], m_addr[2], m_addr[1], m_addr[0]};
   assign i_wr_data = {m_wdata[3], m_wdata[2], m_wdata[1], m_wdata[0]};
   assign i_byte_en = {m_be[3], m_be[2], m_be[1], m_be[0]};

   always #5 i_clk = ~i_clk;

   bus_arbiter_rr #(
      .N_MASTERS (N),
      .ID_W      (2),
      .DATA_W    (DW),
      .TIMEOUT   (8)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_bus_en  (i_bus_en),
      .i_wr_rd   (i_wr_rd),
      .i_wr_data (i_wr_data),
      .i_addr    (i_addr),
      .i_byte_en (i_byte_en),
      .i_atomic  (i_atomic),
      .o_ack     (o_ack),
      .o_err     (o_err),
      .o_rd_data (o_rd_data),
      .i_ack     (i_ack),
      .i_rd_data (i_rd_data),
      .o_bus_en  (o_bus_en),
      .o_wr_en   (o_wr_en),
      .o_wr_data (o_wr_data),
      .o_addr    (o_addr),
      .o_byte_en (o_byte_en),
      .o_atomic  (o_atomic),
      .o_id      (o_id)
   );

   task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: compare any pending expected ack against the DUT, then advance.
   task automatic step();
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_ack", o_ack, e.ack);
         chk("sb_err", o_err, e.err);
         chk("sb_id", o_id, e.id);
         chk("sb_rd_data", o_rd_data, e.rd);
      end else if (o_ack != '0 || o_err != '0) begin
         chk("unexpected_ack", {o_err, o_ack}, '0);
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_step();
      #1;
      chk("idle_bus_en", o_bus_en, '0);
      chk("idle_id", o_id, '0);
      chk("idle_addr", o_addr, '0);
      step();
   endtask

   // Owner m is on the bus now; ack after lat wait cycles with read data rd.
   task automatic serve(input int m, input int lat, input logic [DW-1:0] rd, input bit release_req);
      exp_t e;
      #1;
      chk("grant_id", o_id, m);
      chk("grant_bus_en", o_bus_en, 1);
      chk("mux_addr", o_addr, m_addr[m]);
      chk("mux_wr_data", o_wr_data, m_wdata[m]);
      chk("mux_byte_en", o_byte_en, m_be[m]);
      chk("mux_wr_en", o_wr_en, i_wr_rd[m]);
      chk("mux_atomic", o_atomic, i_atomic[m]);
      repeat (lat) step();
      i_ack     = 1'b1;
      i_rd_data = rd;
      e.id  = 2'(m);
      e.ack = 4'(1 << m);
      e.err = '0;
      e.rd  = (N*DW)'(rd) << (DW * m);
      sb.push_back(e);
      step();
      i_ack     = 1'b0;
      i_rd_data = '0;
      if (release_req) i_bus_en[m] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      exp_t e;
      for (int k = 0; k < N; k++) begin
         m_addr[k]  = 32'h0000_0100 * (k + 1);
         m_wdata[k] = 32'hC0DE_0000 + k;
         m_be[k]    = 4'(k + 1);
      end
      i_wr_rd   = 4'b1010;
      i_atomic  = '0;
      i_ack     = 1'b0;
      i_rd_data = '0;
      i_bus_en  = 4'b1111;
      i_rst     = 1'b0;
      @(posedge i_clk);
      #1;

      // Reset held with every master requesting
      repeat (3) begin
         #1;
         chk("rst_bus_en", o_bus_en, '0);
         chk("rst_ack", o_ack, '0);
         chk("rst_id", o_id, '0);
         step();
      end
      i_rst = 1'b1;
      idle_step();

      // Round robin: 0,1,2,3,0 with ack 2 cycles after grant
      serve(0, 2, 32'hA000_0000, 1'b1);
      idle_step();
      i_bus_en[0] = 1'b1;
      serve(1, 2, 32'hA000_0001, 1'b1);
      idle_step();
      i_bus_en[1] = 1'b1;
      serve(2, 2, 32'hA000_0002, 1'b1);
      idle_step();
      i_bus_en[2] = 1'b1;
      serve(3, 2, 32'hA000_0003, 1'b1);
      idle_step();
      i_bus_en[3] = 1'b1;
      serve(0, 2, 32'hA000_0010, 1'b1);

      // Locked sequence from master 2 while master 0 waits
      i_bus_en = 4'b0101;
      i_atomic = 4'b0100;
      idle_step();
      serve(2, 1, 32'hB000_0001, 1'b0);
      serve(2, 0, 32'hB000_0002, 1'b0);
      i_atomic[2] = 1'b0;
      serve(2, 0, 32'hB000_0003, 1'b1);
      idle_step();
      serve(0, 0, 32'hB000_0010, 1'b1);

      // Watchdog: master 1 never acked, master 3 waiting
      i_bus_en = 4'b1010;
      idle_step();
      repeat (7) step();
      e.id  = 2'd1;
      e.ack = 4'b0010;
      e.err = 4'b0010;
      e.rd  = '0;
      sb.push_back(e);
      #1;
      chk("to_bus_en", o_bus_en, '0);
      step();
      i_bus_en[1] = 1'b0;
      idle_step();

      // Abort by master 3, then master 0 must win from pointer 0
      #1;
      chk("abort_owner", o_id, 3);
      i_bus_en[0] = 1'b1;
      step();
      i_bus_en[3] = 1'b0;
      #1;
      chk("abort_bus_en", o_bus_en, '0);
      step();
      i_bus_en[3] = 1'b1;
      idle_step();
      serve(0, 0, 32'hC000_0000, 1'b1);
      i_bus_en = '0;

      // Read routing for master 2; slave ack in IDLE must be ignored
      m_addr[2]  = 32'h0000_1000;
      i_wr_rd[2] = 1'b0;
      i_bus_en   = 4'b0100;
      i_ack      = 1'b1;
      idle_step();
      i_ack      = 1'b0;
      serve(2, 1, 32'hDEAD_BEEF, 1'b1);

      // Reset in the middle of a transaction
      i_bus_en = 4'b0001;
      idle_step();
      step();
      i_rst = 1'b0;
      step();
      #1;
      chk("midrst_bus_en", o_bus_en, '0);
      chk("midrst_id", o_id, '0);
      i_bus_en = 4'b1010;
      i_rst    = 1'b1;
      idle_step();
      serve(1, 0, 32'hE000_0001, 1'b1);

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
